hdmi_tmds_link: RTL
===================

// Module: hdmi_tmds_link
// PURPOSE
// - Three-channel TMDS link encoder for the HDMI output path. Successor to the fixed DVI-only encoder.
// - Encodes a 24-bit RGB pixel stream and H/V sync into three parallel 10-bit symbols per pixel clock.
// - Optionally emits the HDMI video preamble and leading guard band ahead of every active period.
// - Sits between the video timing/pixel source and the external OSER10/ELVDS serialiser stage.
// PARAMETERS
// - PREAMBLE_LEN  8  cycles of video preamble before the guard band (HDMI_GUARD_EN only)
// - GUARD_LEN     2  cycles of video leading guard band before first pixel (HDMI_GUARD_EN only)
// - OUT_REG       1  1: extra output register stage (+1 latency); 0: none
// PORTS
// - clk        in   1   pixel clock; all logic on rising edge
// - reset_low  in   1   synchronous, active-low reset
// - active     in   1   pixel valid (display enable)
// - h_sync     in   1   horizontal sync, carried on channel 0 as c0
// - v_sync     in   1   vertical sync, carried on channel 0 as c1
// - rgb        in   24  [7:0]=blue->ch0, [15:8]=green->ch1, [23:16]=red->ch2
// - tmds_0     out  10  channel 0 symbol, bit 0 transmitted first
// - tmds_1     out  10  channel 1 symbol
// - tmds_2     out  10  channel 2 symbol
// - active_out out  1   active delayed to align with the tmds_* outputs
// BEHAVIOUR
// - Latency: L = 2 + OUT_REG (+ PREAMBLE_LEN + GUARD_LEN with HDMI_GUARD_EN), input to tmds_*; all inputs delayed equally.
// - Encode pipeline:
//   - Stage 1: popcount, XOR/XNOR choice, q_m[8:0].
//   - Stage 2: DC balance against a per-channel signed 5-bit running disparity, cnt.
// - Video (delayed active=1): standard DVI 1.0 TMDS encode per channel.
//   - Invert when (cnt==0 || n1==n0) selects ~q_m[8], or when sign(cnt) matches the q_m[7:0] majority.
//   - cnt update exactly per DVI 1.0; cnt wraps never (range -16..+15 is sufficient).
// - Control (delayed active=0): symbol selected by {c1,c0}:
//   - 00 -> 1101010100, 01 -> 0010101011, 10 -> 0101010100, 11 -> 1010101011.
//   - ch0 {c1,c0}={v_sync,h_sync}; ch1/ch2 {c1,c0}=00 unless in preamble.
// - cnt for all channels is forced to 0 on every non-video cycle.
// - Reset (reset_low=0 at an edge):
//   - All pipeline/delay registers cleared to blank, sync=0, cnt=0.
//   - tmds_0/1/2 = 1101010100, active_out=0, preamble/guard counter idle.
//   - Reset mid-line aborts the line; first post-reset video needs a fresh active rise.
// - Simultaneous events: a video cycle always has priority over preamble/guard.
//   - Preamble/guard cycles that coincide with delayed active=1 (short blanking) are dropped, never shifted.
// CONFIGURATION
// - Macro HDMI_GUARD_EN.
// - Defined: a rise of the undelayed active starts the period counter. The next PREAMBLE_LEN output cycles (aligned) are the preamble:
//   - ch0 still carries sync.
//   - ch1 {c1,c0}=01 -> 0010101011.
//   - ch2 {c1,c0}=00 -> 1101010100.
// - Defined, continued: the following GUARD_LEN cycles are the guard band:
//   - ch0 = 1011001100, ch1 = 0100110011, ch2 = 1011001100. Sync is ignored.
//   - The first pixel follows immediately.
// - Defined, continued: a new active rise while the counter runs restarts it.
// - Not defined: plain DVI.
//   - No preamble/guard logic or counter.
//   - L = 2 + OUT_REG.
//   - PREAMBLE_LEN/GUARD_LEN are ignored.
// TESTING
// - Reset held 3 cycles, inputs idle -> all tmds_* = 1101010100, active_out=0 from first post-reset edge.
// - Blanking, h_sync=1, v_sync=0 -> tmds_0=0010101011, tmds_1=tmds_2=1101010100 after L cycles.
// - Active, rgb=0x000000 for 2 pixels after blanking:
//   - Each channel gives 0100000000 then 1111111111, cnt -8 then +2.
//   - Returns to 0 on next blank.
// - Active, rgb random 10k pixels:
//   - Output matches the reference-model encode bit-exactly.
//   - |cnt| <= 10 always.
//   - Each TMDS decode returns the input byte.
// - HDMI_GUARD_EN, blanking >= 20:
//   - Active rise at cycle t gives 8 preamble cycles (tmds_1=0010101011) at t+2+OUT_REG.
//   - Then 2 guard cycles (1011001100/0100110011/1011001100), then the first pixel with active_out=1.
// - HDMI_GUARD_EN, blanking of 4 cycles between lines:
//   - Only the last preamble/guard cycles that fall in blanking are emitted.
//   - No pixel is lost or delayed.
//   - Reset asserted mid-preamble -> idle control symbols next cycle.

Source files
------------

// File: rtl/hdmi_tmds_if.sv
// rtl/hdmi_tmds_if.sv - pixel/sync inputs and TMDS symbol outputs of hdmi_tmds_link
interface hdmi_tmds_if;
  logic        active;
  logic        h_sync;
  logic        v_sync;
  logic [23:0] rgb;
  logic [9:0]  tmds_0;
  logic [9:0]  tmds_1;
  logic [9:0]  tmds_2;
  logic        active_out;

  modport master (output active, h_sync, v_sync, rgb,
                  input  tmds_0, tmds_1, tmds_2, active_out);
  modport slave  (input  active, h_sync, v_sync, rgb,
                  output tmds_0, tmds_1, tmds_2, active_out);
endinterface

// File: rtl/hdmi_tmds_link.sv
// rtl/hdmi_tmds_link.sv - three-channel TMDS encoder, optional HDMI preamble/guard band (HDMI_GUARD_EN)
module hdmi_tmds_link #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int OUT_REG      = 1
) (
  input logic       clk,
  input logic       reset_low,
  hdmi_tmds_if.slave link
);
  localparam logic [9:0] CTRL_00  = 10'b1101010100;
  localparam logic [9:0] CTRL_01  = 10'b0010101011;
  localparam logic [9:0] CTRL_10  = 10'b0101010100;
  localparam logic [9:0] CTRL_11  = 10'b1010101011;
  localparam logic [9:0] GUARD_02 = 10'b1011001100;
  localparam logic [9:0] GUARD_1  = 10'b0100110011;

  function automatic logic [9:0] ctrl_sym(input logic c1, input logic c0);
    case ({c1, c0})
      2'b00:   return CTRL_00;
      2'b01:   return CTRL_01;
      2'b10:   return CTRL_10;
      default: return CTRL_11;
    endcase
  endfunction

  function automatic logic [8:0] make_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       xnor_sel;
    logic [8:0] q;
    n1       = 4'($countones(d));
    xnor_sel = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q[0]     = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = xnor_sel ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xnor_sel;
    return q;
  endfunction

  // Active held through reset must drop once before it can start a line.
  logic armed;
  logic act_eff;
  assign act_eff = link.active & armed;

  always_ff @(posedge clk) begin
    if (!reset_low) armed <= 1'b0;
    else            armed <= armed | ~link.active;
  end

  logic        d_active, d_h, d_v;
  logic [23:0] d_rgb;
  logic        pre_mark, guard_mark;

`ifdef HDMI_GUARD_EN
  localparam int DLY = PREAMBLE_LEN + GUARD_LEN;
  localparam int PW  = $clog2(DLY + 1);

  logic [DLY-1:0] act_sr, h_sr, v_sr;
  logic [23:0]    rgb_sr [DLY];
  logic           act_q, pg_run, rise, pg_valid;
  logic [PW-1:0]  pg_cnt, pg_idx;

  assign rise = act_eff & ~act_q;

  // The marker rides alongside the delayed stream, so index 0 is the rise cycle itself.
  always_comb begin
    pg_idx   = rise ? '0 : pg_cnt;
    pg_valid = rise | pg_run;
  end

  assign pre_mark   = pg_valid && (pg_idx < PW'(PREAMBLE_LEN));
  assign guard_mark = pg_valid && !(pg_idx < PW'(PREAMBLE_LEN));

  always_ff @(posedge clk) begin
    if (!reset_low) begin
      act_q  <= 1'b0;
      pg_run <= 1'b0;
      pg_cnt <= '0;
      act_sr <= '0;
      h_sr   <= '0;
      v_sr   <= '0;
      for (int i = 0; i < DLY; i++) rgb_sr[i] <= '0;
    end else begin
      act_q <= act_eff;
      if (rise) begin
        pg_run <= (DLY > 1);
        pg_cnt <= PW'(1);
      end else if (pg_run) begin
        if (pg_cnt == PW'(DLY - 1)) begin
          pg_run <= 1'b0;
          pg_cnt <= '0;
        end else begin
          pg_cnt <= pg_cnt + 1'b1;
        end
      end
      act_sr[0] <= act_eff;
      h_sr[0]   <= link.h_sync;
      v_sr[0]   <= link.v_sync;
      rgb_sr[0] <= link.rgb;
      for (int i = 1; i < DLY; i++) begin
        act_sr[i] <= act_sr[i-1];
        h_sr[i]   <= h_sr[i-1];
        v_sr[i]   <= v_sr[i-1];
        rgb_sr[i] <= rgb_sr[i-1];
      end
    end
  end

  assign d_active = act_sr[DLY-1];
  assign d_h      = h_sr[DLY-1];
  assign d_v      = v_sr[DLY-1];
  assign d_rgb    = rgb_sr[DLY-1];
`else
  assign d_active   = act_eff;
  assign d_h        = link.h_sync;
  assign d_v        = link.v_sync;
  assign d_rgb      = link.rgb;
  assign pre_mark   = 1'b0;
  assign guard_mark = 1'b0;
`endif

  logic       s1_active, s1_pre, s1_guard, s1_h, s1_v;
  logic [8:0] s1_qm [3];
  logic [3:0] s1_n1 [3];

  always_ff @(posedge clk) begin
    if (!reset_low) begin
      s1_active <= 1'b0;
      s1_pre    <= 1'b0;
      s1_guard  <= 1'b0;
      s1_h      <= 1'b0;
      s1_v      <= 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
        s1_qm[ch] <= '0;
        s1_n1[ch] <= '0;
      end
    end else begin
      s1_active <= d_active;
      s1_pre    <= pre_mark;
      s1_guard  <= guard_mark;
      s1_h      <= d_h;
      s1_v      <= d_v;
      for (int ch = 0; ch < 3; ch++) begin
        s1_qm[ch] <= make_qm(d_rgb[8*ch +: 8]);
        s1_n1[ch] <= 4'($countones(make_qm(d_rgb[8*ch +: 8]) & 9'h0FF));
      end
    end
  end

  logic signed [4:0] cnt     [3];
  logic signed [4:0] vid_cnt [3];
  logic [9:0]        vid_sym [3];
  logic signed [5:0] bal     [3];
  logic signed [5:0] c6      [3];
  logic signed [5:0] nxt     [3];

  // bal is n1-n0 of q_m[7:0]; math is done in 6 bits then narrowed, the result always fits 5.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      bal[ch] = $signed({1'b0, s1_n1[ch], 1'b0}) - 6'sd8;
      c6[ch]  = {cnt[ch][4], cnt[ch]};
      if ((cnt[ch] == 5'sd0) || (s1_n1[ch] == 4'd4)) begin
        vid_sym[ch] = {~s1_qm[ch][8], s1_qm[ch][8],
                       s1_qm[ch][8] ? s1_qm[ch][7:0] : ~s1_qm[ch][7:0]};
        nxt[ch]     = s1_qm[ch][8] ? (c6[ch] + bal[ch]) : (c6[ch] - bal[ch]);
      end else if ((!c6[ch][5] && (bal[ch] > 6'sd0)) || (c6[ch][5] && (bal[ch] < 6'sd0))) begin
        vid_sym[ch] = {1'b1, s1_qm[ch][8], ~s1_qm[ch][7:0]};
        nxt[ch]     = c6[ch] + $signed({4'b0, s1_qm[ch][8], 1'b0}) - bal[ch];
      end else begin
        vid_sym[ch] = {1'b0, s1_qm[ch][8], s1_qm[ch][7:0]};
        nxt[ch]     = c6[ch] - $signed({4'b0, ~s1_qm[ch][8], 1'b0}) + bal[ch];
      end
      vid_cnt[ch] = nxt[ch][4:0];
    end
  end

  logic [9:0] s2_sym [3];
  logic       s2_active;

  always_ff @(posedge clk) begin
    if (!reset_low) begin
      s2_active <= 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
        s2_sym[ch] <= CTRL_00;
        cnt[ch]    <= 5'sd0;
      end
    end else begin
      s2_active <= s1_active;
      if (s1_active) begin
        for (int ch = 0; ch < 3; ch++) begin
          s2_sym[ch] <= vid_sym[ch];
          cnt[ch]    <= vid_cnt[ch];
        end
      end else begin
        for (int ch = 0; ch < 3; ch++) cnt[ch] <= 5'sd0;
        s2_sym[0] <= s1_guard ? GUARD_02 : ctrl_sym(s1_v, s1_h);
        s2_sym[1] <= s1_guard ? GUARD_1  : (s1_pre ? CTRL_01 : CTRL_00);
        s2_sym[2] <= s1_guard ? GUARD_02 : CTRL_00;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [9:0] o0, o1, o2;
      logic       oa;
      always_ff @(posedge clk) begin
        if (!reset_low) begin
          o0 <= CTRL_00;
          o1 <= CTRL_00;
          o2 <= CTRL_00;
          oa <= 1'b0;
        end else begin
          o0 <= s2_sym[0];
          o1 <= s2_sym[1];
          o2 <= s2_sym[2];
          oa <= s2_active;
        end
      end
      assign link.tmds_0     = o0;
      assign link.tmds_1     = o1;
      assign link.tmds_2     = o2;
      assign link.active_out = oa;
    end else begin : g_no_out_reg
      assign link.tmds_0     = s2_sym[0];
      assign link.tmds_1     = s2_sym[1];
      assign link.tmds_2     = s2_sym[2];
      assign link.active_out = s2_active;
    end
  endgenerate
endmodule
